// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback stage: exception causes,
// control-register indices, load-size encodings and the flush state enum.
package wb_pkg;

  localparam logic [7:0] EXC_MISALIGNED = 8'h84;

  localparam logic [1:0] CR_PSR = 2'd0;
  localparam logic [1:0] CR_EPC = 2'd1;
  localparam logic [1:0] CR_EFG = 2'd2;
  localparam logic [1:0] CR_IVT = 2'd3;

  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_WORD = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Little-endian load lane selection and sign/zero extension of the data
// memory read word; purely combinational.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0: byte_sel = mem_rdata_i[7:0];
      2'd1: byte_sel = mem_rdata_i[15:8];
      2'd2: byte_sel = mem_rdata_i[23:16];
      2'd3: byte_sel = mem_rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    // Unused encoding 3 behaves as a word load.
    case (ld_size_i)
      LD_BYTE: data_o = {{24{ld_signed_i & byte_sel[7]}}, byte_sel};
      LD_HALF: data_o = {{16{ld_signed_i & half_sel[15]}}, half_sel};
      default: data_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: register-file/control-register writes, exception and
// RFE commit with a timed flush. Optional retire counter under WB_RETIRE_CNT_EN.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        halt,
  input  logic        bubble,
  input  logic [4:0]  tgt_1,
  input  logic [4:0]  tgt_2,
  input  logic [31:0] result_1,
  input  logic [31:0] result_2,
  input  logic [31:0] addr,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_misaligned,
  input  logic [31:0] mem_pc,
  input  logic [7:0]  exc,
  input  logic        tgts_cr,
  input  logic        is_rfe,
  input  logic [3:0]  flags,
  input  logic [31:0] mem_rdata,
  output logic        rf_we_1,
  output logic        rf_we_2,
  output logic [4:0]  rf_tgt_1,
  output logic [4:0]  rf_tgt_2,
  output logic [31:0] rf_data_1,
  output logic [31:0] rf_data_2,
  output logic        exc_in_wb,
  output logic        rfe_in_wb,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        kmode,
  output logic [31:0] epc,
  output logic [3:0]  efg,
  output logic [31:0] ivt_base,
  output logic        flags_restore
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] retired
`endif
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  wb_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        flush_exc_q, flush_exc_d;
  logic        rf_we_1_q, rf_we_1_d, rf_we_2_q, rf_we_2_d;
  logic [4:0]  rf_tgt_1_q, rf_tgt_1_d, rf_tgt_2_q, rf_tgt_2_d;
  logic [31:0] rf_data_1_q, rf_data_1_d, rf_data_2_q, rf_data_2_d;
  logic        redirect_q, redirect_d, flags_restore_q, flags_restore_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        kmode_q, kmode_d;
  logic [31:0] epc_q, epc_d, ivt_q, ivt_d;
  logic [3:0]  efg_q, efg_d;

  logic        en, valid, exc_commit, rfe_commit;
  logic [7:0]  cause;
  logic [31:0] ld_data;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr[31:2];

  load_align u_load_align (
    .mem_rdata_i (mem_rdata),
    .addr_lo_i   (addr[1:0]),
    .ld_size_i   (ld_size),
    .ld_signed_i (ld_signed),
    .data_o      (ld_data)
  );

  assign en         = clk_en && !halt;
  assign valid      = !bubble && (state_q == IDLE);
  assign cause      = (exc != 8'h00) ? exc :
                      (is_misaligned && (is_load || is_store)) ? EXC_MISALIGNED : 8'h00;
  assign exc_commit = valid && (cause != 8'h00);
  assign rfe_commit = valid && is_rfe && (cause == 8'h00);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    flush_exc_d     = flush_exc_q;
    rf_we_1_d       = 1'b0;
    rf_we_2_d       = 1'b0;
    rf_tgt_1_d      = tgt_1;
    rf_tgt_2_d      = tgt_2;
    rf_data_1_d     = is_load ? ld_data : result_1;
    rf_data_2_d     = result_2;
    redirect_d      = 1'b0;
    redirect_pc_d   = redirect_pc_q;
    flags_restore_d = 1'b0;
    kmode_d         = kmode_q;
    epc_d           = epc_q;
    efg_d           = efg_q;
    ivt_d           = ivt_q;

    case (state_q)
      IDLE: begin
        if (exc_commit || rfe_commit) begin
          state_d     = FLUSH;
          cnt_d       = FLUSH_INIT;
          flush_exc_d = exc_commit;
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
    endcase

    if (exc_commit) begin
      epc_d         = mem_pc;
      efg_d         = flags;
      kmode_d       = 1'b1;
      redirect_d    = 1'b1;
      redirect_pc_d = ivt_q + {22'd0, cause, 2'b00};
    end else if (valid) begin
      rf_we_1_d = (tgt_1 != 5'd0) && !tgts_cr && !is_store;
      rf_we_2_d = (tgt_2 != 5'd0) && !tgts_cr && !is_store;
      if (tgts_cr && (tgt_1[4:2] == 3'b000)) begin
        case (tgt_1[1:0])
          CR_PSR: kmode_d = result_1[0];
          CR_EPC: epc_d   = result_1;
          CR_EFG: efg_d   = result_1[3:0];
          CR_IVT: ivt_d   = result_1;
        endcase
      end
      // RFE redirects through the EPC value held before this slot.
      if (is_rfe) begin
        redirect_d      = 1'b1;
        redirect_pc_d   = epc_q;
        kmode_d         = 1'b0;
        flags_restore_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= 3'd0;
      flush_exc_q     <= 1'b0;
      rf_we_1_q       <= 1'b0;
      rf_we_2_q       <= 1'b0;
      rf_tgt_1_q      <= 5'd0;
      rf_tgt_2_q      <= 5'd0;
      rf_data_1_q     <= 32'd0;
      rf_data_2_q     <= 32'd0;
      redirect_q      <= 1'b0;
      redirect_pc_q   <= 32'd0;
      flags_restore_q <= 1'b0;
      kmode_q         <= 1'b1;
      epc_q           <= 32'd0;
      efg_q           <= 4'd0;
      ivt_q           <= RESET_PC_VEC;
    end else if (en) begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      flush_exc_q     <= flush_exc_d;
      rf_we_1_q       <= rf_we_1_d;
      rf_we_2_q       <= rf_we_2_d;
      rf_tgt_1_q      <= rf_tgt_1_d;
      rf_tgt_2_q      <= rf_tgt_2_d;
      rf_data_1_q     <= rf_data_1_d;
      rf_data_2_q     <= rf_data_2_d;
      redirect_q      <= redirect_d;
      redirect_pc_q   <= redirect_pc_d;
      flags_restore_q <= flags_restore_d;
      kmode_q         <= kmode_d;
      epc_q           <= epc_d;
      efg_q           <= efg_d;
      ivt_q           <= ivt_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           retired_q <= 64'd0;
    else if (en && valid && !exc_commit)  retired_q <= retired_q + 64'd1;
  end

  assign retired = retired_q;
`endif

  assign rf_we_1       = rf_we_1_q;
  assign rf_we_2       = rf_we_2_q;
  assign rf_tgt_1      = rf_tgt_1_q;
  assign rf_tgt_2      = rf_tgt_2_q;
  assign rf_data_1     = rf_data_1_q;
  assign rf_data_2     = rf_data_2_q;
  assign exc_in_wb     = (state_q == FLUSH) && flush_exc_q;
  assign rfe_in_wb     = (state_q == FLUSH) && !flush_exc_q;
  assign redirect      = redirect_q;
  assign redirect_pc   = redirect_pc_q;
  assign kmode         = kmode_q;
  assign epc           = epc_q;
  assign efg           = efg_q;
  assign ivt_base      = ivt_q;
  assign flags_restore = flags_restore_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized checks of writeback_stage against a cycle-level
// reference model of the architectural rules.
module tb_writeback_stage;

  localparam int FC = 2;

  logic        clk, rst_n, clk_en, halt, bubble;
  logic [4:0]  tgt_1, tgt_2;
  logic [31:0] result_1, result_2, addr, mem_pc, mem_rdata;
  logic [1:0]  ld_size;
  logic        ld_signed, is_load, is_store, is_misaligned, tgts_cr, is_rfe;
  logic [7:0]  exc;
  logic [3:0]  flags;
  logic        rf_we_1, rf_we_2, exc_in_wb, rfe_in_wb, redirect, kmode, flags_restore;
  logic [4:0]  rf_tgt_1, rf_tgt_2;
  logic [31:0] rf_data_1, rf_data_2, redirect_pc, epc, ivt_base;
  logic [3:0]  efg;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_we1, m_we2, m_redirect, m_frestore, m_kmode, m_kind_exc;
  logic [4:0]  m_tgt1, m_tgt2;
  logic [31:0] m_data1, m_data2, m_rpc, m_epc, m_ivt;
  logic [3:0]  m_efg;
  int          m_left;
  logic [63:0] m_retired;

  writeback_stage #(.FLUSH_CYCLES(FC), .RESET_PC_VEC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .halt(halt), .bubble(bubble),
    .tgt_1(tgt_1), .tgt_2(tgt_2), .result_1(result_1), .result_2(result_2),
    .addr(addr), .ld_size(ld_size), .ld_signed(ld_signed), .is_load(is_load),
    .is_store(is_store), .is_misaligned(is_misaligned), .mem_pc(mem_pc),
    .exc(exc), .tgts_cr(tgts_cr), .is_rfe(is_rfe), .flags(flags),
    .mem_rdata(mem_rdata), .rf_we_1(rf_we_1), .rf_we_2(rf_we_2),
    .rf_tgt_1(rf_tgt_1), .rf_tgt_2(rf_tgt_2), .rf_data_1(rf_data_1),
    .rf_data_2(rf_data_2), .exc_in_wb(exc_in_wb), .rfe_in_wb(rfe_in_wb),
    .redirect(redirect), .redirect_pc(redirect_pc), .kmode(kmode), .epc(epc),
    .efg(efg), .ivt_base(ivt_base), .flags_restore(flags_restore)
`ifdef WB_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_we1 = 0; m_we2 = 0; m_redirect = 0; m_frestore = 0; m_kmode = 1;
    m_kind_exc = 0; m_tgt1 = 0; m_tgt2 = 0; m_data1 = 0; m_data2 = 0;
    m_rpc = 0; m_epc = 0; m_ivt = 32'h0; m_efg = 0; m_left = 0; m_retired = 0;
  endtask

  function automatic logic [31:0] load_value();
    logic [31:0] v;
    int unsigned lane;
    if (ld_size == 2'd0) begin
      lane = addr % 4;
      v = (mem_rdata >> (lane * 8)) & 32'hFF;
      if (ld_signed && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (ld_size == 2'd1) begin
      lane = (addr % 4) / 2;
      v = (mem_rdata >> (lane * 16)) & 32'hFFFF;
      if (ld_signed && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = mem_rdata;
    end
    return v;
  endfunction

  task automatic model_step();
    logic [7:0] cause;
    if (!clk_en || halt) return;
    m_we1 = 0; m_we2 = 0; m_redirect = 0; m_frestore = 0;
    if (m_left > 0) begin
      m_left--;
      return;
    end
    if (bubble) return;
    if (exc != 8'h00) cause = exc;
    else if (is_misaligned && (is_load || is_store)) cause = 8'h84;
    else cause = 8'h00;
    if (cause != 8'h00) begin
      m_epc = mem_pc; m_efg = flags; m_kmode = 1;
      m_redirect = 1; m_rpc = m_ivt + 32'(cause) * 4;
      m_left = FC; m_kind_exc = 1;
      return;
    end
    m_retired++;
    m_we1 = (tgt_1 != 0) && !tgts_cr && !is_store;
    m_we2 = (tgt_2 != 0) && !tgts_cr && !is_store;
    m_tgt1 = tgt_1; m_tgt2 = tgt_2;
    m_data1 = is_load ? load_value() : result_1;
    m_data2 = result_2;
    if (is_rfe) begin
      m_redirect = 1; m_rpc = m_epc; m_kmode = 0; m_frestore = 1;
      m_left = FC; m_kind_exc = 0;
    end
    if (tgts_cr && tgt_1 < 5'd4) begin
      case (tgt_1)
        5'd0: m_kmode = result_1[0];
        5'd1: m_epc = result_1;
        5'd2: m_efg = result_1[3:0];
        default: m_ivt = result_1;
      endcase
    end
  endtask

  task automatic check_all();
    chk("rf_we_1", 64'(rf_we_1), 64'(m_we1));
    chk("rf_we_2", 64'(rf_we_2), 64'(m_we2));
    if (m_we1) begin
      chk("rf_tgt_1", 64'(rf_tgt_1), 64'(m_tgt1));
      chk("rf_data_1", 64'(rf_data_1), 64'(m_data1));
    end
    if (m_we2) begin
      chk("rf_tgt_2", 64'(rf_tgt_2), 64'(m_tgt2));
      chk("rf_data_2", 64'(rf_data_2), 64'(m_data2));
    end
    chk("redirect", 64'(redirect), 64'(m_redirect));
    if (m_redirect) chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
    chk("flags_restore", 64'(flags_restore), 64'(m_frestore));
    chk("exc_in_wb", 64'(exc_in_wb), 64'(m_left > 0 && m_kind_exc));
    chk("rfe_in_wb", 64'(rfe_in_wb), 64'(m_left > 0 && !m_kind_exc));
    chk("kmode", 64'(kmode), 64'(m_kmode));
    chk("epc", 64'(epc), 64'(m_epc));
    chk("efg", 64'(efg), 64'(m_efg));
    chk("ivt_base", 64'(ivt_base), 64'(m_ivt));
`ifdef WB_RETIRE_CNT_EN
    chk("retired", retired, m_retired);
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    bubble = 1; tgt_1 = 0; tgt_2 = 0; result_1 = 0; result_2 = 0; addr = 0;
    ld_size = 0; ld_signed = 0; is_load = 0; is_store = 0; is_misaligned = 0;
    mem_pc = 0; exc = 0; tgts_cr = 0; is_rfe = 0; flags = 0; mem_rdata = 0;
  endtask

  task automatic rand_slot();
    int op;
    idle();
    bubble = ($urandom_range(0, 4) == 0);
    is_rfe = ($urandom_range(0, 9) == 0);
    tgts_cr = !is_rfe && ($urandom_range(0, 6) == 0);
    exc = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    op = is_rfe ? 0 : $urandom_range(0, 2);
    is_load = (op == 1);
    is_store = (op == 2);
    is_misaligned = ($urandom_range(0, 7) == 0);
    tgt_1 = tgts_cr ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
    tgt_2 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    result_1 = $urandom; result_2 = $urandom; addr = $urandom;
    ld_size = 2'($urandom_range(0, 2)); ld_signed = 1'($urandom_range(0, 1));
    mem_rdata = $urandom; mem_pc = $urandom; flags = 4'($urandom_range(0, 15));
    halt = ($urandom_range(0, 15) == 0);
    clk_en = ($urandom_range(0, 15) != 0);
  endtask

  initial begin
    rst_n = 0; halt = 0; clk_en = 1;
    idle();
    model_reset();
    #7;
    check_all();
    chk("rst_kmode", 64'(kmode), 64'd1);
    chk("rst_rf_data_1", 64'(rf_data_1), 64'd0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    #1 rst_n = 1;

    // Byte load, signed, lane 3
    idle(); bubble = 0; is_load = 1; addr = 32'h1003; ld_size = 0; ld_signed = 1;
    mem_rdata = 32'h80FF_1234; tgt_1 = 5; cycle();
    chk("byte_we", 64'(rf_we_1), 64'd1);
    chk("byte_tgt", 64'(rf_tgt_1), 64'd5);
    chk("byte_data", 64'(rf_data_1), 64'hFFFF_FF80);

    // Half load, unsigned, upper lane
    idle(); bubble = 0; is_load = 1; addr = 32'h2002; ld_size = 1; ld_signed = 0;
    mem_rdata = 32'hBEEF_0001; tgt_1 = 9; cycle();
    chk("half_data", 64'(rf_data_1), 64'h0000_BEEF);

    // IVT base := 0x100
    idle(); bubble = 0; tgts_cr = 1; tgt_1 = 3; result_1 = 32'h100; cycle();
    chk("cr3_setup", 64'(ivt_base), 64'h100);

    // Misaligned store
    idle(); bubble = 0; is_store = 1; is_misaligned = 1; mem_pc = 32'h40;
    flags = 4'b1010; tgt_1 = 3; tgt_2 = 4; cycle();
    chk("mis_epc", 64'(epc), 64'h40);
    chk("mis_efg", 64'(efg), 64'hA);
    chk("mis_rpc", 64'(redirect_pc), 64'h310);
    chk("mis_exc1", 64'(exc_in_wb), 64'd1);
    chk("mis_we1", 64'(rf_we_1), 64'd0);
    chk("mis_we2", 64'(rf_we_2), 64'd0);
    idle(); cycle();
    chk("mis_exc2", 64'(exc_in_wb), 64'd1);
    chk("mis_redir2", 64'(redirect), 64'd0);
    cycle();
    chk("mis_exc3", 64'(exc_in_wb), 64'd0);

    // EPC := 0x80, then RFE
    idle(); bubble = 0; tgts_cr = 1; tgt_1 = 1; result_1 = 32'h80; cycle();
    idle(); bubble = 0; is_rfe = 1; cycle();
    chk("rfe_rpc", 64'(redirect_pc), 64'h80);
    chk("rfe_kmode", 64'(kmode), 64'd0);
    chk("rfe_restore", 64'(flags_restore), 64'd1);
    chk("rfe_flush1", 64'(rfe_in_wb), 64'd1);
    chk("rfe_noexc", 64'(exc_in_wb), 64'd0);
    idle(); bubble = 0; is_load = 1; ld_size = 2; tgt_1 = 7; mem_rdata = 32'h1234; cycle();
    chk("rfe_discard", 64'(rf_we_1), 64'd0);
    chk("rfe_restore2", 64'(flags_restore), 64'd0);
    chk("rfe_flush2", 64'(rfe_in_wb), 64'd1);
    idle(); cycle();
    chk("rfe_flush3", 64'(rfe_in_wb), 64'd0);

    // CR write to IVT, then same slot with an upstream exception
    idle(); bubble = 0; tgts_cr = 1; tgt_1 = 3; result_1 = 32'h500; cycle();
    chk("cr3_write", 64'(ivt_base), 64'h500);
    chk("cr3_nowe", 64'(rf_we_1), 64'd0);
    result_1 = 32'h900; exc = 8'h02; cycle();
    chk("cr3_dropped", 64'(ivt_base), 64'h500);
    chk("cr3_exc_rpc", 64'(redirect_pc), 64'h508);
    idle(); cycle(); cycle();

    // Halt during FLUSH holds the counter
    idle(); bubble = 0; exc = 8'h10; cycle();
    idle(); halt = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("halt_hold", 64'(exc_in_wb), 64'd1);
    end
    halt = 0; cycle();
    chk("halt_rel1", 64'(exc_in_wb), 64'd1);
    cycle();
    chk("halt_rel2", 64'(exc_in_wb), 64'd0);

    // Asynchronous reset in the middle of a flush
    idle(); bubble = 0; exc = 8'h20; mem_pc = 32'h1234; cycle();
    idle();
    rst_n = 0;
    #2;
    chk("arst_exc", 64'(exc_in_wb), 64'd0);
    chk("arst_kmode", 64'(kmode), 64'd1);
    chk("arst_epc", 64'(epc), 64'd0);
    chk("arst_ivt", 64'(ivt_base), 64'd0);
    model_reset();
    #1 rst_n = 1;
    idle(); bubble = 0; tgt_1 = 4; result_1 = 32'hCAFE; cycle();
    chk("post_rst_we", 64'(rf_we_1), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_slot();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage; consumes the memory-stage register outputs plus the data-memory read word.
- Performs load extraction and sign extension, register-file and control-register writes, and exception/RFE commit.
- Drives the exc_in_wb / rfe_in_wb flush signals back into the memory stage and the fetch redirect.

Parameters:
- FLUSH_CYCLES, 2: cycles flush stays asserted after an exception or RFE commits; legal range 1-7.
- RESET_PC_VEC, 32'h0000_0000: reset value of the IVT base control register (cr3).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global clock enable.
- halt  in  1  freezes all state.
- bubble  in  1  slot empty.
- tgt_1, tgt_2  in  5  destination regs.
- result_1, result_2  in  32  ALU results.
- addr  in  32  memory address.
- ld_size  in  2  load size: 0 byte, 1 half, 2 word.
- ld_signed  in  1  sign-extend load.
- is_load, is_store, is_misaligned  in  1  memory op flags.
- mem_pc  in  32  instruction PC.
- exc  in  8  upstream exception cause; 0 means none.
- tgts_cr  in  1  write control register cr[tgt_1].
- is_rfe  in  1  return-from-exception.
- flags  in  4  flags of the instruction.
- mem_rdata  in  32  data memory read word.
- rf_we_1, rf_we_2  out  1  register-file write enables.
- rf_tgt_1, rf_tgt_2  out  5  register-file write addresses.
- rf_data_1, rf_data_2  out  32  register-file write data.
- exc_in_wb, rfe_in_wb  out  1  pipeline flush.
- redirect  out  1  one-cycle PC redirect.
- redirect_pc  out  32  redirect target.
- kmode  out  1  kernel mode (cr0 bit 0).
- epc  out  32  cr1.
- efg  out  4  cr2.
- ivt_base  out  32  cr3.
- flags_restore  out  1  one-cycle pulse; load efg into the flags register.

Behaviour:
- Reset values: all outputs 0, except kmode=1, ivt_base=RESET_PC_VEC. State is IDLE, counter 0.
- Nothing changes when halt=1 or clk_en=0. Asynchronous reset overrides halt.
- All outputs are registered; one cycle of latency from capture.
- An instruction is valid when bubble=0 and state=IDLE. Invalid slots produce no writes and no pulses.
- Load data:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Little-endian.
  - Extension per ld_signed.
  - Word loads ignore addr[1:0].
- Register-file write data: rf_data_1 = is_load ? extracted data : result_1; rf_data_2 = result_2.
- rf_we_n = valid && tgt_n!=0 && !tgts_cr && no exception.
- A store never writes a register.
- Exception cause:
  - exc!=0 → exc.
  - Otherwise, is_misaligned && (is_load||is_store) → 8'h84.
  - Otherwise none. exc has priority.
- Exception commit:
  - epc<=mem_pc; efg<=flags; kmode<=1.
  - redirect=1; redirect_pc = ivt_base + {cause,2'b00}.
  - No register-file or control-register write.
- RFE commit (is_rfe, no exception):
  - redirect_pc=epc; kmode<=0; flags_restore=1.
  - Exception takes priority over RFE.
- CR write: valid && tgts_cr && no exception → cr[tgt_1[1:0]] <= result_1.
  - cr0 keeps bit 0 only. cr2 keeps bits 3:0.
  - tgt_1>=4 is ignored.
- A CR write and an exception in the same slot: the exception wins; the CR write is dropped.
- State machine:
  - IDLE → FLUSH on an exception or RFE commit; the counter loads FLUSH_CYCLES-1.
  - FLUSH: exc_in_wb (or rfe_in_wb, whichever caused entry) stays asserted. Incoming slots are discarded. The counter decrements; at 0 return to IDLE.
  - exc_in_wb and rfe_in_wb are never both high.
  - redirect is high only on the first FLUSH cycle.
- A second exception arriving while in FLUSH is discarded.
- Reset mid-FLUSH returns to IDLE immediately with flush deasserted.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: adds a 64-bit retire counter and output port retired [63:0].
  - Increments for every valid instruction that has no exception, RFE included.
  - Wraps modulo 2^64. Reset to 0. Frozen by halt/clk_en.
- Undefined: no port and no counter.

Decomposition:
- Package wb_pkg holds:
  - cause constant EXC_MISALIGNED=8'h84.
  - CR index constants CR_PSR=0, CR_EPC=1, CR_EFG=2, CR_IVT=3.
  - ld_size encodings.
  - State enum IDLE/FLUSH.
- Sub-module load_align: combinational load extraction from mem_rdata, addr[1:0], ld_size and ld_signed to 32-bit data.

Test Plan:
- Byte load: addr=32'h1003, ld_size=0, ld_signed=1, mem_rdata=32'h80FF_1234, tgt_1=5 → rf_we_1=1, rf_tgt_1=5, rf_data_1=32'hFFFF_FF80.
- Half load: addr=32'h2002, ld_size=1, ld_signed=0, mem_rdata=32'hBEEF_0001 → rf_data_1=32'h0000_BEEF.
- Misaligned store: is_store=1, is_misaligned=1, mem_pc=32'h40, flags=4'b1010, ivt_base=32'h100 → epc=32'h40, efg=4'b1010, redirect_pc=32'h310, exc_in_wb high 2 cycles, rf_we_n=0.
- RFE with epc=32'h80 and kmode=1 → redirect_pc=32'h80, kmode=0, flags_restore pulse, rfe_in_wb high FLUSH_CYCLES cycles; the following non-bubble slot produces no writes.
- CR write with tgt_1=3, tgts_cr=1, result_1=32'h500 → ivt_base=32'h500, rf_we_1=0. The same slot with exc=8'h02 → ivt_base unchanged.
- halt=1 during FLUSH holds the counter; rst_n low mid-FLUSH → exc_in_wb=0, kmode=1 asynchronously.
